ir_cmd_decoder: RTL and testbench

- Sits between the IR NEC receiver and the main robot FSM.
- Consumes the receiver's 32-bit decoded frame and its data-ready strobe, and validates the command-byte complement.
- Classifies each valid frame as a new press or an auto-repeat, and tracks key-held state with a timeout.
- Queues accepted command bytes in a small FIFO, presented to the FSM over a valid/ready handshake.

---
 rtl/ir_cmd_decoder.sv | 172 +++++++++++++++++
 tb/tb_ir_cmd_decoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ir_cmd_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ir_cmd_decoder: validates NEC frames, tags repeats, tracks key-held and  |
// | queues commands for the FSM. Optional macro: IR_ADDR_FILTER_EN.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ir_cmd_decoder #(
  parameter int          FIFO_DEPTH    = 4,
  parameter int          REPEAT_WINDOW = 7_500_000,
  parameter int          HOLD_TIMEOUT  = 12_500_000,
  parameter logic [15:0] ADDR          = 16'h6B86
) (
  input  logic        clk,
  input  logic        iRST_n,
  input  logic        ir_data_ready,
  input  logic [31:0] ir_data,
  output logic [7:0]  cmd_byte,
  output logic        cmd_repeat,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        key_held,
  output logic        overflow,
  output logic [7:0]  err_count
);

  localparam int C_AW   = $clog2(FIFO_DEPTH);
  localparam int C_RW_W = $clog2(REPEAT_WINDOW + 1);
  localparam int C_HT_W = $clog2(HOLD_TIMEOUT + 1);

  localparam logic [C_RW_W-1:0] C_RW_MAX  = C_RW_W'(REPEAT_WINDOW);
  localparam logic [C_HT_W-1:0] C_HT_LAST = C_HT_W'(HOLD_TIMEOUT - 1);
  localparam logic [C_AW:0]     C_DEPTH   = (C_AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LATCH = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;

`ifdef IR_ADDR_FILTER_EN
  localparam logic C_ADDR_ANY = 1'b0;
`else
  localparam logic C_ADDR_ANY = 1'b1;
`endif

  logic              r_rdy_q;
  logic [1:0]        r_state;
  logic [31:0]       r_frame;
  logic [23:0]       r_last_code;
  logic              r_last_valid;
  logic [C_RW_W-1:0] r_rep_timer;
  logic [C_HT_W-1:0] r_hold_timer;
  logic              r_key_held;
  logic              r_overflow;
  logic [7:0]        r_err_count;
  logic [8:0]        r_mem [FIFO_DEPTH];
  logic [C_AW:0]     r_wr_ptr;
  logic [C_AW:0]     r_rd_ptr;

  logic       w_rise;
  logic       w_in_check;
  logic       w_cmpl_ok;
  logic       w_addr_ok;
  logic       w_valid_frame;
  logic       w_reject;
  logic       w_is_repeat;
  logic       w_empty;
  logic       w_full;
  logic       w_pop;
  logic       w_push;
  logic       w_drop;
  logic [8:0] w_head;

  assign w_rise        = ir_data_ready & ~r_rdy_q;
  assign w_in_check    = (r_state == S_CHECK);
  assign w_cmpl_ok     = (r_frame[31:24] == ~r_frame[23:16]);
  assign w_addr_ok     = (r_frame[15:0] == ADDR) | C_ADDR_ANY;
  assign w_valid_frame = w_in_check & w_cmpl_ok & w_addr_ok;
  assign w_reject      = w_in_check & ~(w_cmpl_ok & w_addr_ok);
  assign w_is_repeat   = r_last_valid && (r_frame[23:0] == r_last_code)
                         && (r_rep_timer < C_RW_MAX);

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = ((r_wr_ptr - r_rd_ptr) == C_DEPTH);
  assign w_pop   = ~w_empty & cmd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push  = w_valid_frame & (~w_full | w_pop);
  assign w_drop  = w_valid_frame & w_full & ~w_pop;
  assign w_head  = r_mem[r_rd_ptr[C_AW-1:0]];

  assign cmd_valid  = ~w_empty;
  assign cmd_byte   = cmd_valid ? w_head[7:0] : 8'h00;
  assign cmd_repeat = cmd_valid & w_head[8];
  assign key_held   = r_key_held;
  assign overflow   = r_overflow;
  assign err_count  = r_err_count;

  always_ff @(posedge clk or negedge iRST_n) begin
    if (!iRST_n) begin
      r_rdy_q <= 1'b0;
      r_state <= S_IDLE;
      r_frame <= 32'h0;
    end else begin
      r_rdy_q <= ir_data_ready;
      case (r_state)
        S_IDLE:  if (w_rise) r_state <= S_LATCH;
        S_LATCH: begin
          r_frame <= ir_data;
          r_state <= S_CHECK;
        end
        S_CHECK: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge iRST_n) begin
    if (!iRST_n) begin
      r_last_code  <= 24'h0;
      r_last_valid <= 1'b0;
      r_rep_timer  <= '0;
    end else if (w_valid_frame) begin
      r_last_code  <= r_frame[23:0];
      r_last_valid <= 1'b1;
      r_rep_timer  <= '0;
    end else if (r_rep_timer != C_RW_MAX) begin
      r_rep_timer  <= r_rep_timer + C_RW_W'(1);
    end
  end

  // A frame in the timeout cycle takes priority and restarts the hold.
  always_ff @(posedge clk or negedge iRST_n) begin
    if (!iRST_n) begin
      r_key_held   <= 1'b0;
      r_hold_timer <= '0;
    end else if (w_valid_frame) begin
      r_key_held   <= 1'b1;
      r_hold_timer <= '0;
    end else if (r_key_held) begin
      if (r_hold_timer == C_HT_LAST) begin
        r_key_held   <= 1'b0;
        r_hold_timer <= '0;
      end else begin
        r_hold_timer <= r_hold_timer + C_HT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge iRST_n) begin
    if (!iRST_n) begin
      r_err_count <= 8'h00;
      r_overflow  <= 1'b0;
    end else begin
      if (w_reject && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge iRST_n) begin
    if (!iRST_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (C_AW + 1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (C_AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[C_AW-1:0]] <= {w_is_repeat, r_frame[23:16]};
  end

endmodule
`default_nettype wire

// File: tb/tb_ir_cmd_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ir_cmd_decoder: scoreboard bench for ir_cmd_decoder with shortened    |
// | timers. Covers IR_ADDR_FILTER_EN when defined. Revision: 1.0             |
// +--------------------------------------------------------------------------+
module tb_ir_cmd_decoder;

  localparam int C_RW = 750;
  localparam int C_HT = 1250;

  logic        clk = 1'b0;
  logic        iRST_n;
  logic        ir_data_ready;
  logic [31:0] ir_data;
  logic [7:0]  cmd_byte;
  logic        cmd_repeat;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        key_held;
  logic        overflow;
  logic [7:0]  err_count;

  int         total = 0;
  int         bad   = 0;
  logic [8:0] sb[$];
  logic [7:0] exp_err;

  ir_cmd_decoder #(
    .FIFO_DEPTH    (4),
    .REPEAT_WINDOW (C_RW),
    .HOLD_TIMEOUT  (C_HT),
    .ADDR          (16'h6B86)
  ) dut (
    .clk           (clk),
    .iRST_n        (iRST_n),
    .ir_data_ready (ir_data_ready),
    .ir_data       (ir_data),
    .cmd_byte      (cmd_byte),
    .cmd_repeat    (cmd_repeat),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .key_held      (key_held),
    .overflow      (overflow),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [7:0] c);
    return {~c, c, 16'h6B86};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_frame(input logic [31:0] d);
    ir_data       = d;
    ir_data_ready = 1'b1;
  endtask

  task automatic send(input logic [31:0] d);
    start_frame(d);
    tick(4);
    ir_data_ready = 1'b0;
    tick(2);
  endtask

  // Scoreboard drain: every accepted head must match the oldest expectation.
  always @(negedge clk) begin
    if (iRST_n && cmd_valid && cmd_ready) begin
      if (sb.size() == 0) chk("sb_unexpected_pop", 32'(cmd_valid), 32'd0);
      else chk("sb_entry", 32'({cmd_repeat, cmd_byte}), 32'(sb.pop_front()));
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    iRST_n = 1'b0; ir_data_ready = 1'b0; ir_data = 32'h0; cmd_ready = 1'b1;
    tick(3);
    chk("rst_valid",  32'(cmd_valid),  32'd0);
    chk("rst_byte",   32'(cmd_byte),   32'd0);
    chk("rst_repeat", 32'(cmd_repeat), 32'd0);
    chk("rst_held",   32'(key_held),   32'd0);
    chk("rst_ovf",    32'(overflow),   32'd0);
    chk("rst_err",    32'(err_count),  32'd0);
    iRST_n = 1'b1;
    tick(2);

    // First frame: latency and head contents.
    sb.push_back({1'b0, 8'h12});
    start_frame(32'hED12_6B86);
    tick(2);
    chk("lat_n2_valid", 32'(cmd_valid), 32'd0);
    tick(1);
    chk("lat_n3_valid", 32'(cmd_valid),  32'd1);
    chk("first_byte",   32'(cmd_byte),   32'h12);
    chk("first_repeat", 32'(cmd_repeat), 32'd0);
    chk("first_held",   32'(key_held),   32'd1);
    tick(1);
    ir_data_ready = 1'b0;
    tick(96);

    // Same code inside the window, then well outside it.
    sb.push_back({1'b1, 8'h12});
    start_frame(32'hED12_6B86);
    tick(4);
    ir_data_ready = 1'b0;
    tick(796);
    sb.push_back({1'b0, 8'h12});
    send(32'hED12_6B86);
    chk("rep_drained", 32'(sb.size()), 32'd0);

    // Overflow with a stalled consumer.
    cmd_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic [7:0] c;
      c = 8'h21 + 8'(i);
      if (i < 4) sb.push_back({1'b0, c});
      send(mk(c));
      if (i == 3) chk("ovf_at_full", 32'(overflow), 32'd0);
    end
    chk("ovf_set",     32'(overflow),  32'd1);
    chk("ovf_err",     32'(err_count), 32'd0);
    chk("ovf_head",    32'(cmd_byte),  32'h21);
    chk("ovf_valid",   32'(cmd_valid), 32'd1);

    // Push while full with a pop in the same cycle.
    sb.push_back({1'b0, 8'h27});
    start_frame(mk(8'h27));
    tick(2);
    cmd_ready = 1'b1;
    tick(1);
    chk("fullpop_valid", 32'(cmd_valid), 32'd1);
    tick(1);
    ir_data_ready = 1'b0;
    tick(10);
    chk("fullpop_empty", 32'(cmd_valid), 32'd0);
    chk("fullpop_sb",    32'(sb.size()), 32'd0);

`ifdef IR_ADDR_FILTER_EN
    send(32'hED12_0000);
    exp_err = 8'd1;
    chk("addr_nopush", 32'(cmd_valid), 32'd0);
`else
    sb.push_back({1'b0, 8'h12});
    send(32'hED12_0000);
    exp_err = 8'd0;
`endif
    chk("addr_err", 32'(err_count), 32'(exp_err));

    // Complement errors and saturation.
    send(32'h1212_6B86);
    chk("cmpl_err",    32'(err_count), 32'(exp_err + 8'd1));
    chk("cmpl_held",   32'(key_held),  32'd1);
    chk("cmpl_nopush", 32'(cmd_valid), 32'd0);
    for (int i = 0; i < 299; i++) send(32'h1212_6B86);
    chk("err_sat", 32'(err_count), 32'd255);

    // Hold timeout measured from the CHECK cycle.
    chk("hold_pre", 32'(key_held), 32'd0);
    sb.push_back({1'b0, 8'h30});
    start_frame(mk(8'h30));
    tick(3);
    chk("hold_set", 32'(key_held), 32'd1);
    tick(1);
    ir_data_ready = 1'b0;
    tick(C_HT - 2);
    chk("hold_last", 32'(key_held), 32'd1);
    tick(1);
    chk("hold_fall", 32'(key_held), 32'd0);

    // Frame whose CHECK lands on the timeout cycle keeps key_held.
    sb.push_back({1'b0, 8'h40});
    start_frame(mk(8'h40));
    tick(4);
    ir_data_ready = 1'b0;
    tick(C_HT - 4);
    sb.push_back({1'b0, 8'h41});
    start_frame(mk(8'h41));
    tick(3);
    chk("race_held", 32'(key_held), 32'd1);
    tick(1);
    ir_data_ready = 1'b0;
    tick(C_HT - 2);
    chk("race_last", 32'(key_held), 32'd1);
    tick(1);
    chk("race_fall", 32'(key_held), 32'd0);

    // Reset while the frame is in LATCH.
    start_frame(mk(8'h55));
    tick(1);
    iRST_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(cmd_valid), 32'd0);
    chk("mrst_ovf",   32'(overflow),  32'd0);
    chk("mrst_err",   32'(err_count), 32'd0);
    chk("mrst_byte",  32'(cmd_byte),  32'd0);
    ir_data_ready = 1'b0;
    tick(2);
    iRST_n = 1'b1;
    tick(8);
    chk("mrst_after_valid", 32'(cmd_valid), 32'd0);
    chk("mrst_after_held",  32'(key_held),  32'd0);
    chk("sb_left",          32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
